// File: rtl/johnson_pkg.sv
// ============================================================
// johnson_pkg: shared FSM state type and phase-width helper
// Rev 1.0
// ============================================================
`default_nettype none

package johnson_pkg;

  typedef enum logic [0:0] {
    ST_UNLOCK = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Bits needed to hold a step index 0..2N-1.
  function automatic int phase_w(input int n);
    return $clog2(2 * n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/johnson_code_decode.sv
// ============================================================
// johnson_code_decode: combinational Johnson code check and step decode
// Rev 1.0
// ============================================================
`default_nettype none

module johnson_code_decode
  import johnson_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]            din,
  output logic                    legal,
  output logic [phase_w(N)-1:0]   phase
);

  localparam int              PW   = phase_w(N);
  localparam logic [PW-1:0]   c_N  = PW'(N);

  logic [N-1:0]  w_x;
  logic [PW-1:0] w_cnt;

  // Fold the MSB=1 half onto the MSB=0 half: ~din is then a run of ones from the LSB.
  assign w_x = din[N-1] ? ~din : din;

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < N; i++) begin
      w_cnt = w_cnt + {{(PW-1){1'b0}}, w_x[i]};
    end
  end

  assign legal = ((w_x & (w_x + {{(N-1){1'b0}}, 1'b1})) == '0);
  assign phase = din[N-1] ? (c_N + w_cnt) : w_cnt;

endmodule

`default_nettype wire

// File: rtl/johnson_decoder.sv
// ============================================================
// johnson_decoder: twisted-ring chaser monitor (decode, track, lock, errors)
// Rev 1.0
// ============================================================
`default_nettype none

module johnson_decoder
  import johnson_pkg::*;
#(
  parameter int N        = 8,
  parameter int LOCK_LEN = 3,
  parameter int ERR_W    = 8
) (
  input  logic                  clk,
  input  logic                  rs,
  input  logic [N-1:0]          din,
  output logic [phase_w(N)-1:0] phase,
  output logic                  step,
  output logic                  hold,
  output logic                  locked,
  output logic                  code_err,
  output logic                  seq_err,
  output logic [ERR_W-1:0]      err_count
);

  localparam int               PW     = phase_w(N);
  localparam int               LC_W   = $clog2(LOCK_LEN + 1);
  localparam logic [PW-1:0]    c_PMAX = PW'(2 * N - 1);
  localparam logic [LC_W-1:0]  c_LOCK = LC_W'(LOCK_LEN);

  logic                w_legal;
  logic [PW-1:0]       w_dec;
  logic [PW-1:0]       w_phase_inc;

  state_t              r_state, w_nxt_state;
  logic [PW-1:0]       r_phase, w_nxt_phase;
  logic                r_prev_valid, w_nxt_pv;
  logic [LC_W-1:0]     r_lock_cnt, w_nxt_cnt, w_cnt_inc;
  logic [ERR_W-1:0]    r_err_count, w_nxt_err;
  logic                r_step, r_hold, r_code_err, r_seq_err;
  logic                w_step, w_hold, w_code_err, w_seq_err, w_legal_tr;

  johnson_code_decode #(.N(N)) u_decode (
    .din   (din),
    .legal (w_legal),
    .phase (w_dec)
  );

  assign w_phase_inc = (r_phase == c_PMAX) ? '0 : r_phase + PW'(1);
  assign w_cnt_inc   = r_lock_cnt + LC_W'(1);

  always_comb begin
    w_nxt_phase = r_phase;
    w_nxt_pv    = r_prev_valid;
    w_nxt_cnt   = r_lock_cnt;
    w_nxt_state = r_state;
    w_nxt_err   = r_err_count;
    w_step      = 1'b0;
    w_hold      = 1'b0;
    w_code_err  = 1'b0;
    w_seq_err   = 1'b0;
    w_legal_tr  = 1'b0;

    if (!w_legal) begin
      w_code_err  = 1'b1;
      w_nxt_pv    = 1'b0;
      w_nxt_cnt   = '0;
      w_nxt_state = ST_UNLOCK;
    end else if (!r_prev_valid) begin
      w_nxt_phase = w_dec;
      w_nxt_pv    = 1'b1;
      w_nxt_cnt   = '0;
    end else if (w_dec == r_phase) begin
      w_hold     = 1'b1;
      w_legal_tr = 1'b1;
    end else if (w_dec == w_phase_inc) begin
      w_step      = 1'b1;
      w_nxt_phase = w_dec;
      w_legal_tr  = 1'b1;
    end else begin
      // Resync to the new phase so a permanently shifted chaser can relock.
      w_seq_err   = 1'b1;
      w_nxt_phase = w_dec;
      w_nxt_cnt   = '0;
      w_nxt_state = ST_UNLOCK;
    end

    if (w_legal_tr && (r_state == ST_UNLOCK)) begin
      w_nxt_cnt = w_cnt_inc;
      if (w_cnt_inc == c_LOCK) begin
        w_nxt_state = ST_LOCKED;
      end
    end

    if ((w_code_err || w_seq_err) && (r_err_count != '1)) begin
      w_nxt_err = r_err_count + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rs) begin
      r_state      <= ST_UNLOCK;
      r_phase      <= '0;
      r_prev_valid <= 1'b0;
      r_lock_cnt   <= '0;
      r_err_count  <= '0;
      r_step       <= 1'b0;
      r_hold       <= 1'b0;
      r_code_err   <= 1'b0;
      r_seq_err    <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_phase      <= w_nxt_phase;
      r_prev_valid <= w_nxt_pv;
      r_lock_cnt   <= w_nxt_cnt;
      r_err_count  <= w_nxt_err;
      r_step       <= w_step;
      r_hold       <= w_hold;
      r_code_err   <= w_code_err;
      r_seq_err    <= w_seq_err;
    end
  end

  assign phase     = r_phase;
  assign step      = r_step;
  assign hold      = r_hold;
  assign locked    = (r_state == ST_LOCKED);
  assign code_err  = r_code_err;
  assign seq_err   = r_seq_err;
  assign err_count = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_johnson_decoder.sv
// ============================================================
// tb_johnson_decoder: directed + random checks against a sequence-table model
// Rev 1.0
// ============================================================
`default_nettype none

module tb_johnson_decoder;

  localparam int c_LOCK_LEN = 3;

  logic       clk = 1'b0;
  logic       rs  = 1'b0;
  logic [7:0] din = 8'h00;
  logic [3:0] phase;
  logic       step, hold, locked, code_err, seq_err;
  logic [7:0] err_count;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] tbl [16];
  int m_phase, m_run, m_err;
  bit m_pv, e_step, e_hold, e_code, e_seq;

  johnson_decoder #(.N(8), .LOCK_LEN(c_LOCK_LEN), .ERR_W(8)) dut (
    .clk       (clk),
    .rs        (rs),
    .din       (din),
    .phase     (phase),
    .step      (step),
    .hold      (hold),
    .locked    (locked),
    .code_err  (code_err),
    .seq_err   (seq_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  function automatic int lookup(input logic [7:0] d);
    for (int k = 0; k < 16; k++) if (tbl[k] == d) return k;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("phase",     {28'd0, phase},     m_phase);
    chk("step",      {31'd0, step},      {31'd0, e_step});
    chk("hold",      {31'd0, hold},      {31'd0, e_hold});
    chk("code_err",  {31'd0, code_err},  {31'd0, e_code});
    chk("seq_err",   {31'd0, seq_err},   {31'd0, e_seq});
    chk("locked",    {31'd0, locked},    {31'd0, (m_run >= c_LOCK_LEN)});
    chk("err_count", {24'd0, err_count}, m_err);
  endtask

  task automatic model(input logic [7:0] d);
    int idx;
    idx = lookup(d);
    {e_step, e_hold, e_code, e_seq} = 4'b0000;
    if (idx < 0) begin
      e_code = 1; m_pv = 0; m_run = 0;
    end else if (!m_pv) begin
      m_phase = idx; m_pv = 1; m_run = 0;
    end else if (idx == m_phase) begin
      e_hold = 1; m_run++;
    end else if (idx == (m_phase + 1) % 16) begin
      e_step = 1; m_phase = idx; m_run++;
    end else begin
      e_seq = 1; m_phase = idx; m_run = 0;
    end
    if ((e_code || e_seq) && m_err < 255) m_err++;
  endtask

  task automatic apply(input logic [7:0] d);
    din = d;
    @(posedge clk);
    #1;
    model(d);
    check_all();
  endtask

  task automatic do_reset();
    rs  = 1'b1;
    din = 8'h5A;
    @(posedge clk);
    #1;
    rs = 1'b0;
    m_phase = 0; m_pv = 0; m_run = 0; m_err = 0;
    {e_step, e_hold, e_code, e_seq} = 4'b0000;
    check_all();
  endtask

  initial begin
    logic [7:0] c;
    int r;
    c = 8'h00;
    for (int k = 0; k < 16; k++) begin
      tbl[k] = c;
      c = {c[6:0], ~c[7]};
    end

    // Initial lock-in from 0x00.
    do_reset();
    apply(8'h00); apply(8'h01); apply(8'h03); apply(8'h07);
    chk("lock_after_4", {31'd0, locked}, 32'd1);
    chk("phase_3", {28'd0, phase}, 32'd3);

    // Walk up to 0xE0, then wrap through 0xC0, 0x80, 0x00.
    for (int p = 4; p <= 13; p++) apply(tbl[p]);
    apply(8'hC0); apply(8'h80); apply(8'h00);
    chk("wrap_phase0", {28'd0, phase}, 32'd0);
    chk("wrap_step", {31'd0, step}, 32'd1);

    // Pause at 0x0F.
    apply(8'h01); apply(8'h03); apply(8'h07);
    for (int i = 0; i < 5; i++) apply(8'h0F);
    chk("hold_pulse", {31'd0, hold}, 32'd1);
    chk("hold_phase4", {28'd0, phase}, 32'd4);

    // Illegal code while locked at 0x03, then relock.
    do_reset();
    apply(8'h00); apply(8'h01); apply(8'h03); apply(8'h03);
    apply(8'h05);
    chk("cerr_pulse", {31'd0, code_err}, 32'd1);
    chk("cerr_phase", {28'd0, phase}, 32'd2);
    chk("cerr_cnt", {24'd0, err_count}, 32'd1);
    apply(8'h07); apply(8'h0F); apply(8'h1F); apply(8'h3F);
    chk("relock", {31'd0, locked}, 32'd1);

    // Phase jump while locked at 0x03.
    do_reset();
    apply(8'h00); apply(8'h01); apply(8'h03); apply(8'h03);
    apply(8'h0F);
    chk("serr_pulse", {31'd0, seq_err}, 32'd1);
    chk("serr_phase", {28'd0, phase}, 32'd4);
    chk("serr_unlock", {31'd0, locked}, 32'd0);

    // Reset while locked at 0xFE.
    do_reset();
    for (int p = 5; p <= 9; p++) apply(tbl[p]);
    chk("lock_fe", {31'd0, locked}, 32'd1);
    do_reset();
    chk("rst_outs", {phase, step, hold, locked, code_err, seq_err, err_count}, 32'd0);

    // Randomised traffic biased toward plausible chaser behaviour.
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 9);
      if ($urandom_range(0, 199) == 0) do_reset();
      else if (r <= 4) apply(tbl[(m_phase + 1) % 16]);
      else if (r <= 6) apply(tbl[m_phase]);
      else if (r == 7) apply(tbl[$urandom_range(0, 15)]);
      else apply(8'($urandom));
    end

    // Saturation of the error counter.
    do_reset();
    for (int i = 0; i < 600; i++) apply((i % 2 == 0) ? 8'h05 : 8'h01);
    chk("sat_255", {24'd0, err_count}, 32'd255);
    apply(8'h05);
    chk("sat_hold", {24'd0, err_count}, 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
